// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and sizing helpers for the sequential multiplier
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    // The counter has to hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_sign_unit.sv
// rtl/mult_sign_unit.sv - operand magnitudes, result sign and conditional product negate
module mult_sign_unit #(
    parameter int WIDTH = 4
) (
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     value_a,
    input  logic [WIDTH-1:0]     value_b,
    input  logic                 negate,
    input  logic [2*WIDTH-1:0]   acc,
    output logic [WIDTH-1:0]     mag_a,
    output logic [WIDTH-1:0]     mag_b,
    output logic                 neg,
    output logic [2*WIDTH-1:0]   result
);

    // The most negative value negates to itself, which read as unsigned is its magnitude.
    always_comb begin
        mag_a  = (signed_mode && value_a[WIDTH-1]) ? (~value_a + 1'b1) : value_a;
        mag_b  = (signed_mode && value_b[WIDTH-1]) ? (~value_b + 1'b1) : value_b;
        neg    = signed_mode & (value_a[WIDTH-1] ^ value_b[WIDTH-1]);
        result = negate ? (~acc + 1'b1) : acc;
    end

endmodule

// File: rtl/seq_mult_param.sv
// rtl/seq_mult_param.sv - shift-add multiplier with start/done handshake; optional EARLY_TERM_EN
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     inputA,
    input  logic [WIDTH-1:0]     inputB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);

    state_t            state;
    state_t            state_next;

    logic [PW-1:0]     acc;
    logic [PW-1:0]     mcand;
    logic [WIDTH-1:0]  mplier;
    logic [CW-1:0]     cnt;
    logic              neg;

    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic              neg_in;
    logic [PW-1:0]     signed_result;

    logic              load_op;
    logic              run_step;
    logic              fin_load;
    logic              run_exit;

    mult_sign_unit #(
        .WIDTH (WIDTH)
    ) u_sign (
        .signed_mode (signed_mode),
        .value_a     (inputA),
        .value_b     (inputB),
        .negate      (neg),
        .acc         (acc),
        .mag_a       (mag_a),
        .mag_b       (mag_b),
        .neg         (neg_in),
        .result      (signed_result)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Early exit fires when the multiplier would shift out to zero: no set bits remain.
`ifdef EARLY_TERM_EN
    assign run_exit = (cnt == CW'(1)) || ((mplier >> 1) == '0);
`else
    assign run_exit = (cnt == CW'(1));
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (run_exit) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_op  = 1'b0;
        run_step = 1'b0;
        fin_load = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: load_op = start;
            RUN: begin
                run_step = 1'b1;
                busy     = 1'b1;
            end
            FIN: begin
                fin_load = 1'b1;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= fin_load;
            if (load_op) begin
                mcand  <= {{WIDTH{1'b0}}, mag_a};
                mplier <= mag_b;
                acc    <= '0;
                cnt    <= CW'(WIDTH);
                neg    <= neg_in;
            end
            if (run_step) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end
            if (fin_load) begin
                product <= signed_result;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// tb/tb_seq_mult_param.sv - directed and table-driven checks of seq_mult_param at WIDTH=4
module tb_seq_mult_param;

    localparam int W = 4;
`ifdef EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic           sys_clk;
    logic           sys_rst;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   inputA;
    logic [W-1:0]   inputB;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int passed = 0;
    int total  = 0;

    seq_mult_param #(.WIDTH(W)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start       (start),
        .signed_mode (signed_mode),
        .inputA      (inputA),
        .inputB      (inputB),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        logic           sm;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int exp_lat(input logic sm, input logic [W-1:0] b);
        logic [W-1:0] m;
        int k;
        m = (sm && b[W-1]) ? (~b + 1'b1) : b;
        k = 1;
        for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
        return EARLY ? k + 1 : W + 1;
    endfunction

    function automatic logic [2*W-1:0] ref_mult(input logic sm, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        int x;
        int y;
        int p;
        x = sm ? int'($signed(a)) : int'(a);
        y = sm ? int'($signed(b)) : int'(b);
        p = x * y;
        return p[2*W-1:0];
    endfunction

    // Ends in the done cycle so a caller may start the next op back-to-back.
    task automatic run_op(input string name, input logic sm, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp, input bit inj);
        int lat;
        bit got;
        bit busy_ok;
        @(negedge sys_clk);
        start = 1'b1; signed_mode = sm; inputA = a; inputB = b;
        @(posedge sys_clk); #1;
        start = 1'b0;
        chk({name, " busy_after_accept"}, busy, 1);
        busy_ok = 1'b1; got = 1'b0; lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (inj) begin
                start = (i == 1);
                inputA = 4'h1; inputB = 4'h1; signed_mode = ~sm;
            end
            @(posedge sys_clk); #1;
            if (done) begin
                lat = i; got = 1'b1;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        chk({name, " done_seen"}, got, 1);
        chk({name, " latency"}, lat, exp_lat(sm, b));
        chk({name, " busy_during_op"}, busy_ok, 1);
        chk({name, " product"}, product, exp);
        chk({name, " busy_in_done"}, busy, 0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 4'hF, 4'hF, 8'hE1};
        vecs[1]  = '{1'b1, 4'h8, 4'h7, 8'hC8};
        vecs[2]  = '{1'b1, 4'h8, 4'h8, 8'h40};
        vecs[3]  = '{1'b1, 4'h5, 4'hD, 8'hF1};
        vecs[4]  = '{1'b0, 4'h0, 4'h9, 8'h00};
        vecs[5]  = '{1'b1, 4'h0, 4'hB, 8'h00};
        vecs[6]  = '{1'b0, 4'h7, 4'h0, 8'h00};
        vecs[7]  = '{1'b1, 4'h8, 4'h0, 8'h00};
        vecs[8]  = '{1'b0, 4'hF, 4'h2, 8'h1E};
        vecs[9]  = '{1'b1, 4'hF, 4'h2, 8'hFE};
        vecs[10] = '{1'b0, 4'h8, 4'h8, 8'h40};
        vecs[11] = '{1'b1, 4'h7, 4'h7, 8'h31};
        vecs[12] = '{1'b0, 4'h3, 4'h1, 8'h03};
        vecs[13] = '{1'b1, 4'hF, 4'hF, 8'h01};
        vecs[14] = '{1'b0, 4'h1, 4'h8, 8'h08};

        sys_rst = 1'b1; start = 1'b0; signed_mode = 1'b0; inputA = '0; inputB = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset product", product, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
            @(posedge sys_clk); #1;
            chk($sformatf("vec%0d done_pulse_width", i), done, 0);
            chk($sformatf("vec%0d product_held", i), product, vecs[i].exp);
        end

        // A start during RUN, with different operands and mode, must be dropped.
        run_op("ignore_start", 1'b0, 4'hF, 4'hF, 8'hE1, 1'b1);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("ignore_start no_queued_op", busy, 0);
        chk("ignore_start product_kept", product, 8'hE1);

        // Back-to-back: the second start lands in the first op's done cycle.
        run_op("b2b_first", 1'b0, 4'h3, 4'h5, 8'h0F, 1'b0);
        run_op("b2b_second", 1'b1, 4'h6, 4'hE, 8'hF4, 1'b0);

        // Reset sampled at E2 of a 15*15 op aborts it with no done pulse.
        @(negedge sys_clk);
        start = 1'b1; signed_mode = 1'b0; inputA = 4'hF; inputB = 4'hF;
        @(posedge sys_clk); #1;
        start = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset product", product, 0);
        sys_rst = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge sys_clk); #1;
                if (done) seen = 1'b1;
            end
            chk("midreset no_done", seen, 0);
        end
        run_op("after_reset", 1'b0, 4'h5, 4'h3, 8'h0F, 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic           rsm;
            logic [W-1:0]   ra;
            logic [W-1:0]   rb;
            rsm = 1'($urandom_range(1, 0));
            ra  = W'($urandom_range(15, 0));
            rb  = W'($urandom_range(15, 0));
            run_op($sformatf("rand%0d", i), rsm, ra, rb, ref_mult(rsm, ra, rb), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
